// File: rtl/bus_arbiter_mux_if.sv
// Bus source selector interface: control inputs, source buses and registered bus outputs.
// The master side drives mode, sel and the per-source data/req/lock vectors.
// The slave side (the selector) returns grant, bus_out, bus_valid, bus_src and sel_err.
interface bus_arbiter_mux_if #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 24,
  parameter int SELW  = $clog2(NSRC)
);
  logic                    mode;
  logic [SELW-1:0]         sel;
  logic [NSRC*WIDTH-1:0]   src_data;
  logic [NSRC-1:0]         src_req;
  logic [NSRC-1:0]         src_lock;
  logic [NSRC-1:0]         grant;
  logic [WIDTH-1:0]        bus_out;
  logic                    bus_valid;
  logic [SELW-1:0]         bus_src;
  logic                    sel_err;

  modport master (
    output mode, sel, src_data, src_req, src_lock,
    input  grant, bus_out, bus_valid, bus_src, sel_err
  );

  modport slave (
    input  mode, sel, src_data, src_req, src_lock,
    output grant, bus_out, bus_valid, bus_src, sel_err
  );
endinterface

// File: rtl/bus_arbiter_mux.sv
// Registered bus source selector: direct select or round-robin arbitration with lock.
// Latency: one cycle, inputs sampled at an edge are visible on the outputs after that edge.
// No backpressure: a grant lasts one cycle unless the owner holds req and lock together.
module bus_arbiter_mux #(
  parameter int              WIDTH       = 32,
  parameter int              NSRC        = 24,
  parameter int              SELW        = $clog2(NSRC),
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
  input logic              clock,
  input logic              clear,
  bus_arbiter_mux_if.slave bus
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t            state_q, state_d;
  logic [SELW-1:0]   owner_q, owner_d;
  logic [SELW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [SELW-1:0]   bus_src_q, bus_src_d;
  logic [NSRC-1:0]   grant_q, grant_d;
  logic [WIDTH-1:0]  bus_out_q, bus_out_d;
  logic              bus_valid_q, bus_valid_d;
  logic              sel_err_q, sel_err_d;

  logic [WIDTH-1:0]  src_arr [NSRC];
  logic [SELW-1:0]   search_from;
  logic [NSRC-1:0]   req_mask;
  logic              found;
  logic [SELW-1:0]   winner;
  logic              owner_keep;

  function automatic logic [SELW-1:0] next_idx(input logic [SELW-1:0] i);
    if (int'(i) >= NSRC - 1) return '0;
    return i + SELW'(1);
  endfunction

  // Unpack the flat source bus into one word per source.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      src_arr[i] = bus.src_data[i*WIDTH +: WIDTH];
    end
  end

  // Search inputs: when an owner releases, the search starts just past it and skips it.
  always_comb begin
    owner_keep  = (state_q == OWN) && bus.src_req[owner_q] && bus.src_lock[owner_q];
    search_from = (state_q == OWN) ? next_idx(owner_q) : rr_ptr_q;
    req_mask    = bus.src_req;
    if (state_q == OWN) req_mask[owner_q] = 1'b0;
  end

  // Round-robin search: first set request at or after search_from, wrapping at NSRC.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NSRC; k++) begin
      int idx;
      idx = int'(search_from) + k;
      if (idx >= NSRC) idx = idx - NSRC;
      if (!found && req_mask[idx]) begin
        found  = 1'b1;
        winner = SELW'(idx);
      end
    end
  end

  // Next-state and next-output logic for both modes.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    bus_src_d   = bus_src_q;
    grant_d     = grant_q;
    bus_out_d   = bus_out_q;
    bus_valid_d = bus_valid_q;
    sel_err_d   = 1'b0;

    if (!bus.mode) begin
      // Direct mode: any ownership is dropped, rr_ptr is left alone.
      state_d = IDLE;
      grant_d = '0;
      if (int'(bus.sel) < NSRC) begin
        bus_out_d   = src_arr[bus.sel];
        bus_src_d   = bus.sel;
        bus_valid_d = 1'b1;
      end else begin
        bus_out_d   = DEFAULT_VAL;
        bus_src_d   = '0;
        bus_valid_d = 1'b0;
        sel_err_d   = 1'b1;
      end
    end else if (owner_keep) begin
      // Locked owner keeps the bus; its data is re-sampled every cycle.
      bus_out_d   = src_arr[owner_q];
      bus_src_d   = owner_q;
      bus_valid_d = 1'b1;
    end else begin
      if (state_q == OWN) rr_ptr_d = next_idx(owner_q);
      if (found) begin
        grant_d         = '0;
        grant_d[winner] = 1'b1;
        bus_out_d       = src_arr[winner];
        bus_src_d       = winner;
        bus_valid_d     = 1'b1;
        if (bus.src_lock[winner]) begin
          state_d = OWN;
          owner_d = winner;
        end else begin
          state_d  = IDLE;
          rr_ptr_d = next_idx(winner);
        end
      end else begin
        state_d     = IDLE;
        grant_d     = '0;
        bus_valid_d = 1'b0;
      end
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      bus_src_q   <= '0;
      grant_q     <= '0;
      bus_out_q   <= '0;
      bus_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      bus_src_q   <= bus_src_d;
      grant_q     <= grant_d;
      bus_out_q   <= bus_out_d;
      bus_valid_q <= bus_valid_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.bus_out   = bus_out_q;
  assign bus.bus_valid = bus_valid_q;
  assign bus.bus_src   = bus_src_q;
  assign bus.sel_err   = sel_err_q;

endmodule
